// File: rtl/serial_sub_nbit.sv
// Bit-serial N-bit subtractor: diff = a - b, LSB first, one bit per clock,
// using a single full-subtractor cell with a registered borrow and a start/done handshake.
module serial_sub_nbit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out,
  output logic         ovf
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic d;
    logic bout;
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
    return {bout, d};
  endfunction

  state_t        state_q, state_d;
  logic [N-1:0]  sa_q, sa_d;
  logic [N-1:0]  sb_q, sb_d;
  logic [N-1:0]  res_q, res_d;
  logic          bw_q, bw_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_msb_q, a_msb_d;
  logic          b_msb_q, b_msb_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          borrow_q, borrow_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [1:0]    fs_s;
  logic [N-1:0]  res_shift_s;

  assign fs_s        = full_sub(sa_q[0], sb_q[0], bw_q);
  assign res_shift_s = {fs_s[0], res_q[N-1:1]};

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    bw_d     = bw_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          bw_d    = 1'b0;
          cnt_d   = '0;
          a_msb_d = a[N-1];
          b_msb_d = b[N-1];
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sa_d  = {1'b0, sa_q[N-1:1]};
        sb_d  = {1'b0, sb_q[N-1:1]};
        res_d = res_shift_s;
        bw_d  = fs_s[1];
        if (cnt_q == CNT_LAST) begin
          // Result regs are only touched here, so they stay put across a new accept.
          state_d  = S_DONE;
          diff_d   = res_shift_s;
          borrow_d = fs_s[1];
          ovf_d    = (a_msb_q != b_msb_q) && (fs_s[0] != a_msb_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      bw_q     <= bw_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;

endmodule
